// File: rtl/seq_mem_d2_lat.sv
// seq_mem_d2_lat: 2-D sequential memory with a pipelined read latency of 1..4, independent read/write ports and a sticky out-of-bounds flag.
// Optional macro SEQ_MEM_WR_BYPASS_EN: a same-cycle write to the same address is forwarded to the read (write-first).
module seq_mem_d2_lat #(
    parameter int WIDTH        = 32,
    parameter int D0_SIZE      = 16,
    parameter int D1_SIZE      = 16,
    parameter int D0_IDX_SIZE  = 4,
    parameter int D1_IDX_SIZE  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [D0_IDX_SIZE-1:0] addr0,
    input  logic [D1_IDX_SIZE-1:0] addr1,
    input  logic                   read_en,
    output logic [WIDTH-1:0]       read_data,
    output logic                   read_done,
    input  logic                   write_en,
    input  logic [WIDTH-1:0]       write_data,
    output logic                   write_done,
    output logic                   oob_err
);
    localparam int DEPTH = D0_SIZE * D1_SIZE;
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("seq_mem_d2_lat: READ_LATENCY must be 1..4");
    end
    if ((64'd1 << D0_IDX_SIZE) < 64'(D0_SIZE) || (64'd1 << D1_IDX_SIZE) < 64'(D1_SIZE)) begin : g_bad_idx
        $error("seq_mem_d2_lat: index width too small for array size");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic             oob;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] rd_word;
    logic             last_v;
    logic [WIDTH-1:0] last_d;

    assign oob = 32'(addr0) >= D0_SIZE || 32'(addr1) >= D1_SIZE;
    assign idx = AW'(32'(addr0) * D1_SIZE + 32'(addr1));

`ifdef SEQ_MEM_WR_BYPASS_EN
    assign rd_word = oob ? '0 : write_en ? write_data : mem[idx];
`else
    assign rd_word = oob ? '0 : mem[idx];
`endif

    always_ff @(posedge clk) begin
        if (reset && write_en && !oob) mem[idx] <= write_data;
    end

    // Stage 0 is the array access itself; later stages only delay the word.
    if (READ_LATENCY == 1) begin : g_l1
        assign last_v = read_en;
        assign last_d = rd_word;
    end else begin : g_ln
        logic [READ_LATENCY-2:0] pv;
        logic [WIDTH-1:0]        pd [READ_LATENCY-1];
        always_ff @(posedge clk) begin
            pv[0] <= reset && read_en;
            pd[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
                pv[k] <= reset && pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
        assign last_v = pv[READ_LATENCY-2];
        assign last_d = pd[READ_LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data  <= '0;
            read_done  <= 1'b0;
            write_done <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            read_done  <= last_v;
            write_done <= write_en;
            if (last_v) read_data <= last_d;
            if ((read_en || write_en) && oob) oob_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_mem_d2_lat.sv
// tb_seq_mem_d2_lat: three instances (latency 1, 3, 4; 8x16 array) driven in lockstep and checked
// against directed expectations and a flat-array reference model with per-latency result timing.
module tb_seq_mem_d2_lat;
    localparam int LAT [3] = '{1, 3, 4};
`ifdef SEQ_MEM_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  addr0 = '0;
    logic [3:0]  addr1 = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] rdata [3];
    logic [2:0]  rdone, wdone, oerr;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    seq_mem_d2_lat #(.WIDTH(32), .D0_SIZE(8), .D1_SIZE(16), .D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1), .read_en(read_en), .read_data(rdata[0]),
        .read_done(rdone[0]), .write_en(write_en), .write_data(write_data), .write_done(wdone[0]), .oob_err(oerr[0]));
    seq_mem_d2_lat #(.WIDTH(32), .D0_SIZE(8), .D1_SIZE(16), .D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .READ_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1), .read_en(read_en), .read_data(rdata[1]),
        .read_done(rdone[1]), .write_en(write_en), .write_data(write_data), .write_done(wdone[1]), .oob_err(oerr[1]));
    seq_mem_d2_lat #(.WIDTH(32), .D0_SIZE(8), .D1_SIZE(16), .D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .READ_LATENCY(4)) dut_l4 (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1), .read_en(read_en), .read_data(rdata[2]),
        .read_done(rdone[2]), .write_en(write_en), .write_data(write_data), .write_done(wdone[2]), .oob_err(oerr[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a0, input int a1, input logic [31:0] d);
        addr0 = 4'(a0);
        addr1 = 4'(a1);
        write_data = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        read_en = 1'b1;
        addr0 = 4'd2;
        addr1 = 4'd5;
        repeat (3) begin
            tick();
            n_cmp++;
            if (rdone !== 3'b000) begin n_bad++; $display("FAIL reset_done: got %b want 000", rdone); end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdata[i] !== 32'h0) begin n_bad++; $display("FAIL reset_data[L%0d]: got %h want 0", LAT[i], rdata[i]); end
        end
        n_cmp++;
        if (oerr !== 3'b000 || wdone !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got oob %b wdone %b want 000 000", oerr, wdone); end
        reset = 1'b1;
        read_en = 1'b0;
        tick();
        n_cmp++;
        if (rdone !== 3'b000) begin n_bad++; $display("FAIL reset_exit_done: got %b want 000", rdone); end
    endtask

    task automatic test_latency();
        wr(2, 5, 32'hDEADBEEF);
        read_en = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            read_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rdone[i] !== (c == LAT[i])) begin n_bad++; $display("FAIL lat_done[L%0d] c%0d: got %b want %b", LAT[i], c, rdone[i], c == LAT[i]); end
                if (c >= LAT[i]) begin
                    n_cmp++;
                    if (rdata[i] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat_data[L%0d] c%0d: got %h want deadbeef", LAT[i], c, rdata[i]); end
                end
            end
        end
    endtask

    task automatic test_pipelined();
        for (int k = 0; k < 4; k++) wr(0, k, 32'(k + 1));
        addr0 = 4'd0;
        for (int c = 1; c <= 8; c++) begin
            read_en = c <= 4;
            addr1 = 4'(c - 1);
            tick();
            for (int i = 0; i < 3; i++) begin
                int  k = c - LAT[i];
                bit  e = k >= 0 && k < 4;
                n_cmp++;
                if (rdone[i] !== e) begin n_bad++; $display("FAIL pipe_done[L%0d] c%0d: got %b want %b", LAT[i], c, rdone[i], e); end
                if (e) begin
                    n_cmp++;
                    if (rdata[i] !== 32'(k + 1)) begin n_bad++; $display("FAIL pipe_data[L%0d] c%0d: got %h want %h", LAT[i], c, rdata[i], k + 1); end
                end
            end
        end
        read_en = 1'b0;
    endtask

    task automatic test_write_read();
        wr(7, 15, 32'h12345678);
        n_cmp++;
        if (wdone !== 3'b111) begin n_bad++; $display("FAIL wr_done: got %b want 111", wdone); end
        read_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            read_en = 1'b0;
            if (c == 1) begin
                n_cmp++;
                if (wdone !== 3'b000) begin n_bad++; $display("FAIL wr_done_pulse: got %b want 000", wdone); end
            end
            for (int i = 0; i < 3; i++) if (c == LAT[i]) begin
                n_cmp++;
                if (rdone[i] !== 1'b1 || rdata[i] !== 32'h12345678) begin
                    n_bad++; $display("FAIL wr_rd[L%0d]: got done %b data %h want 1 12345678", LAT[i], rdone[i], rdata[i]);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] exp_first = BYP ? 32'hB : 32'hA;
        wr(3, 3, 32'hA);
        write_data = 32'hB;
        write_en = 1'b1;
        read_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            write_en = 1'b0;
            read_en = 1'b0;
            if (c == 1) begin
                n_cmp++;
                if (wdone !== 3'b111) begin n_bad++; $display("FAIL col_wdone: got %b want 111", wdone); end
            end
            for (int i = 0; i < 3; i++) if (c == LAT[i]) begin
                n_cmp++;
                if (rdone[i] !== 1'b1 || rdata[i] !== exp_first) begin
                    n_bad++; $display("FAIL col_rd[L%0d]: got done %b data %h want 1 %h", LAT[i], rdone[i], rdata[i], exp_first);
                end
            end
        end
        read_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            read_en = 1'b0;
            for (int i = 0; i < 3; i++) if (c == LAT[i]) begin
                n_cmp++;
                if (rdone[i] !== 1'b1 || rdata[i] !== 32'hB) begin
                    n_bad++; $display("FAIL col_later[L%0d]: got done %b data %h want 1 0000000b", LAT[i], rdone[i], rdata[i]);
                end
            end
        end
    endtask

    task automatic test_oob();
        n_cmp++;
        if (oerr !== 3'b000) begin n_bad++; $display("FAIL oob_pre: got %b want 000", oerr); end
        wr(1, 0, 32'h77);
        wr(9, 0, 32'h55);
        n_cmp++;
        if (wdone !== 3'b111 || oerr !== 3'b111) begin n_bad++; $display("FAIL oob_wr: got wdone %b oob %b want 111 111", wdone, oerr); end
        for (int r = 0; r < 2; r++) begin
            logic [31:0] e = r == 0 ? 32'h0 : 32'h77;
            addr0 = r == 0 ? 4'd9 : 4'd1;
            addr1 = 4'd0;
            read_en = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                tick();
                read_en = 1'b0;
                for (int i = 0; i < 3; i++) if (c == LAT[i]) begin
                    n_cmp++;
                    if (rdone[i] !== 1'b1 || rdata[i] !== e) begin
                        n_bad++; $display("FAIL oob_rd%0d[L%0d]: got done %b data %h want 1 %h", r, LAT[i], rdone[i], rdata[i], e);
                    end
                end
            end
        end
        repeat (3) tick();
        n_cmp++;
        if (oerr !== 3'b111) begin n_bad++; $display("FAIL oob_sticky: got %b want 111", oerr); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++;
        if (oerr !== 3'b000) begin n_bad++; $display("FAIL oob_clear: got %b want 000", oerr); end
    endtask

    task automatic test_reset_midflight();
        addr0 = 4'd2;
        addr1 = 4'd5;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        n_cmp++;
        if (rdone !== 3'b001 || rdata[0] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL mid_l1: got done %b data %h want 001 deadbeef", rdone, rdata[0]);
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdata[i] !== 32'h0) begin n_bad++; $display("FAIL mid_data[L%0d]: got %h want 0", LAT[i], rdata[i]); end
        end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (rdone !== 3'b000) begin n_bad++; $display("FAIL mid_done c%0d: got %b want 000", c, rdone); end
            tick();
        end
        read_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            read_en = 1'b0;
            for (int i = 0; i < 3; i++) if (c == LAT[i]) begin
                n_cmp++;
                if (rdone[i] !== 1'b1 || rdata[i] !== 32'hDEADBEEF) begin
                    n_bad++; $display("FAIL mid_after[L%0d]: got done %b data %h want 1 deadbeef", LAT[i], rdone[i], rdata[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] mm [128];
        logic [31:0] hist_d [$];
        int          hist_c [$];
        int          head [3] = '{0, 0, 0};
        logic [31:0] last [3] = '{0, 0, 0};
        bit          m_oob = 1'b0;
        int          cyc = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int a = 0; a < 128; a++) begin
            mm[a] = $urandom;
            wr(a / 16, a % 16, mm[a]);
        end
        tick();
        for (int n = 0; n < 400; n++) begin
            bit          re = n < 394 && $urandom_range(0, 1) == 1;
            bit          we = n < 394 && $urandom_range(0, 2) == 0;
            int          a0 = $urandom_range(0, 9);
            int          a1 = $urandom_range(0, 15);
            logic [31:0] wd = $urandom;
            bit          bad = a0 >= 8;
            addr0 = 4'(a0);
            addr1 = 4'(a1);
            read_en = re;
            write_en = we;
            write_data = wd;
            if (re) begin
                hist_d.push_back(bad ? 32'h0 : (BYP && we) ? wd : mm[a0 * 16 + a1]);
                hist_c.push_back(cyc);
            end
            if (we && !bad) mm[a0 * 16 + a1] = wd;
            if ((re || we) && bad) m_oob = 1'b1;
            tick();
            cyc++;
            for (int i = 0; i < 3; i++) begin
                bit e = head[i] < hist_c.size() && hist_c[head[i]] + LAT[i] == cyc;
                if (e) begin
                    last[i] = hist_d[head[i]];
                    head[i]++;
                end
                n_cmp++;
                if (rdone[i] !== e || rdata[i] !== last[i]) begin
                    n_bad++; $display("FAIL rand_rd[L%0d] cyc%0d: got done %b data %h want %b %h", LAT[i], cyc, rdone[i], rdata[i], e, last[i]);
                end
            end
            n_cmp++;
            if (wdone !== {3{we}} || oerr !== {3{m_oob}}) begin
                n_bad++; $display("FAIL rand_flags cyc%0d: got wdone %b oob %b want %b %b", cyc, wdone, oerr, {3{we}}, {3{m_oob}});
            end
        end
        read_en = 1'b0;
        write_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (head[i] != hist_c.size()) begin n_bad++; $display("FAIL rand_drain[L%0d]: got %0d reads want %0d", LAT[i], head[i], hist_c.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pipelined();
        test_write_read();
        test_collision();
        test_oob();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
